// File: rtl/qs_srt_pkg.sv
// qs_srt shared types: instruction/ucode formats, opcode and sequencer state
// encodings, and the link-register index used by CALL/RET.
package qs_srt_pkg;

  localparam int IMM_W = 8;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MOV   = 4'd3,
    OP_JCC   = 4'd4,
    OP_CALL  = 4'd5,
    OP_RET   = 4'd6,
    OP_AWAIT = 4'd7,
    OP_DONE  = 4'd8
  } opcode_t;

  // Link register: CALL writes it, RET reads it.
  localparam logic [3:0] BLINK = 4'hF;

  typedef struct packed {
    opcode_t          opcode;
    logic [3:0]       cc;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [IMM_W-1:0] imm;
  } inst_t;

  typedef struct packed {
    opcode_t          op;
    logic [3:0]       cc;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [IMM_W-1:0] imm;
    logic             wr_en;
    logic             is_nop;
    logic             is_jump;
    logic             is_ret;
    logic             is_await;
    logic             is_done;
    logic             invalid_inst;
  } ucode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_CF_WAIT, S_AWAIT
  } seq_state_t;

endpackage

// File: rtl/qs_srt_ucode_decoder.sv
// Combinational ucode decoder shared by the qs_srt engine.
//   inst  : raw instruction word
//   ucode : decoded fields plus class flags; unknown opcodes set invalid_inst
module qs_srt_ucode_decoder
  import qs_srt_pkg::*;
(
  input  inst_t  inst,
  output ucode_t ucode
);

  always_comb begin
    ucode     = '0;
    ucode.op  = inst.opcode;
    ucode.cc  = inst.cc;
    ucode.rd  = inst.rd;
    ucode.rs  = inst.rs;
    ucode.imm = inst.imm;
    case (inst.opcode)
      OP_NOP:                ucode.is_nop = 1'b1;
      OP_ADD, OP_SUB, OP_MOV: ucode.wr_en = 1'b1;
      OP_JCC:                ucode.is_jump = 1'b1;
      OP_CALL: begin
        ucode.is_jump = 1'b1;
        ucode.wr_en   = 1'b1;
        ucode.rd      = BLINK;
      end
      OP_RET: begin
        ucode.is_ret = 1'b1;
        ucode.rs     = BLINK;
      end
      OP_AWAIT:              ucode.is_await = 1'b1;
      OP_DONE:               ucode.is_done  = 1'b1;
      default:               ucode.invalid_inst = 1'b1;
    endcase
  end

endmodule

// File: rtl/qs_srt_ucode_sequencer.sv
// qs_srt microcode fetch/issue sequencer. One instruction in flight.
//   start_vld/start_pc/start_rdy : program launch (accepted only in IDLE)
//   busy, done (1-cycle), err (sticky until next start)
//   rom_en/rom_addr/rom_data     : synchronous ROM, data one cycle after rom_en
//   issue_vld/issue_ucode/issue_pc/issue_rdy : handshake to execute
//   cf_vld/cf_taken/cf_target    : branch resolution for JCC/CALL/RET
//   await_evt                    : wake for AWAIT
module qs_srt_ucode_sequencer
  import qs_srt_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_vld,
  input  logic [PC_W-1:0] start_pc,
  output logic            start_rdy,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            rom_en,
  output logic [PC_W-1:0] rom_addr,
  input  inst_t           rom_data,
  output logic            issue_vld,
  output ucode_t          issue_ucode,
  output logic [PC_W-1:0] issue_pc,
  input  logic            issue_rdy,
  input  logic            cf_vld,
  input  logic            cf_taken,
  input  logic [PC_W-1:0] cf_target,
  input  logic            await_evt
);

  seq_state_t      state, state_d;
  logic [PC_W-1:0] pc, pc_d, pc_inc;
  logic            err_d, done_d;
  inst_t           inst_q;

  qs_srt_ucode_decoder u_dec (.inst(inst_q), .ucode(issue_ucode));

  assign pc_inc   = pc + PC_W'(1);  // wraps modulo 2^PC_W
  assign rom_addr = pc;
  assign issue_pc = pc;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      inst_q <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      err   <= err_d;
      done  <= done_d;
      if (state == S_LOAD) inst_q <= rom_data;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    err_d     = err;
    done_d    = 1'b0;
    start_rdy = 1'b0;
    rom_en    = 1'b0;
    issue_vld = 1'b0;
    case (state)
      S_IDLE: begin
        start_rdy = 1'b1;
        if (start_vld) begin
          pc_d    = start_pc;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rom_en  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_ISSUE;
      S_ISSUE: begin
        // Terminating and stalling classes never reach execute.
        if (issue_ucode.invalid_inst) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (issue_ucode.is_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (issue_ucode.is_await) begin
          state_d = S_AWAIT;
        end else if (issue_ucode.is_nop) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          issue_vld = 1'b1;
          if (issue_rdy) begin
            // Redirects wait for execute to resolve the next pc.
            if (issue_ucode.is_jump || issue_ucode.is_ret) begin
              state_d = S_CF_WAIT;
            end else begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_CF_WAIT: begin
        if (cf_vld) begin
          pc_d    = cf_taken ? cf_target : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_AWAIT: begin
        if (await_evt) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_qs_srt_ucode_sequencer.sv
module tb_qs_srt_ucode_sequencer;
  import qs_srt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_vld = 1'b0;
  logic [7:0] start_pc = '0;
  logic       start_rdy, busy, done, err, rom_en, issue_vld;
  logic [7:0] rom_addr, issue_pc;
  inst_t      rom_data = '0;
  ucode_t     issue_ucode;
  logic       issue_rdy = 1'b1;
  logic       cf_vld = 1'b0, cf_taken = 1'b0;
  logic [7:0] cf_target = '0;
  logic       await_evt = 1'b0;

  qs_srt_ucode_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start_vld(start_vld), .start_pc(start_pc),
    .start_rdy(start_rdy), .busy(busy), .done(done), .err(err),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .issue_vld(issue_vld), .issue_ucode(issue_ucode), .issue_pc(issue_pc),
    .issue_rdy(issue_rdy), .cf_vld(cf_vld), .cf_taken(cf_taken),
    .cf_target(cf_target), .await_evt(await_evt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Microcode ROM model: registered read.
  inst_t rom_mem [256];
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  function automatic inst_t mk(input logic [3:0] op, input logic [3:0] rd,
                               input logic [7:0] imm);
    inst_t i;
    i = '0;
    i.opcode = opcode_t'(op);
    i.rd = rd;
    i.rs = 4'h2;
    i.imm = imm;
    return i;
  endfunction

  typedef struct {
    logic [7:0] pc;
    opcode_t    op;
    logic [3:0] rd;
    int         cyc;  // -1 : issue cycle not checked
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard: every handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (issue_vld === 1'b1 && issue_rdy === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue: pc=%h op=%0d, none expected", issue_pc, issue_ucode.op);
      end else begin
        exp_t e;
        logic ej, er;
        e = sb.pop_front();
        ej = (e.op == OP_JCC || e.op == OP_CALL);
        er = (e.op == OP_RET);
        if (issue_pc !== e.pc || issue_ucode.op !== e.op || issue_ucode.rd !== e.rd ||
            issue_ucode.is_jump !== ej || issue_ucode.is_ret !== er ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL issue: got pc=%h op=%0d rd=%h j=%b r=%b cyc=%0d, want pc=%h op=%0d rd=%h j=%b r=%b cyc=%0d",
                   issue_pc, issue_ucode.op, issue_ucode.rd, issue_ucode.is_jump,
                   issue_ucode.is_ret, cyc, e.pc, e.op, e.rd, ej, er, e.cyc);
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] p, output int t);
    @(posedge clk); #1;
    start_vld = 1'b1;
    start_pc  = p;
    t = cyc;
    @(posedge clk); #1;
    start_vld = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (issue_vld) ok = 1'b1;
    end
  endtask

  task automatic wait_done(output int c, output bit ok);
    ok = 1'b0;
    c = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; c = cyc; end
    end
  endtask

  // Called right after the negedge of a redirect issue cycle.
  task automatic resolve_cf(input logic tk, input logic [7:0] tgt,
                            output logic en, output logic [7:0] addr);
    @(posedge clk); #1;
    cf_vld = 1'b1; cf_taken = tk; cf_target = tgt;
    @(posedge clk); #1;
    cf_vld = 1'b0; cf_taken = 1'b0;
    en = rom_en; addr = rom_addr;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (start_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        rom_en !== 1'b0 || issue_vld !== 1'b0 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b busy=%b done=%b err=%b en=%b iv=%b addr=%h, want 1 0 0 0 0 0 00",
               start_rdy, busy, done, err, rom_en, issue_vld, rom_addr);
    end
  endtask

  task automatic test_straight_line;
    int t, d; bit ok;
    issue_rdy = 1'b1;
    do_start(8'h10, t);
    sb.push_back('{8'h10, OP_ADD, 4'h1, t + 3});
    sb.push_back('{8'h11, OP_MOV, 4'h2, t + 6});
    wait_done(d, ok);
    n_chk++;
    if (!ok || d != t + 10 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL straight_done: ok=%b cyc=%0d busy=%b err=%b, want cyc=%0d busy=0 err=0",
               ok, d, busy, err, t + 10);
    end
  endtask

  task automatic test_backpressure;
    int t, d; bit ok;
    ucode_t u0; logic [7:0] p0;
    issue_rdy = 1'b0;
    do_start(8'h50, t);
    wait_issue(ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_issue: timeout, want issue_vld"); end
    u0 = issue_ucode; p0 = issue_pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (issue_vld !== 1'b1 || issue_ucode !== u0 || issue_pc !== p0 ||
          rom_en !== 1'b0 || rom_addr !== 8'h50) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: iv=%b pc=%h en=%b addr=%h, want iv=1 pc=%h en=0 addr=50",
                 i, issue_vld, issue_pc, rom_en, rom_addr, p0);
      end
    end
    sb.push_back('{8'h50, OP_ADD, 4'h3, -1});
    @(posedge clk); #1 issue_rdy = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (rom_en !== 1'b1 || rom_addr !== 8'h51) begin
      n_fail++;
      $display("FAIL bp_advance: en=%b addr=%h, want en=1 addr=51", rom_en, rom_addr);
    end
    wait_done(d, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_done: timeout, want done"); end
  endtask

  task automatic test_jcc;
    int t, d; bit ok; logic en; logic [7:0] a;
    for (int k = 0; k < 2; k++) begin
      do_start(8'h20, t);
      sb.push_back('{8'h20, OP_JCC, 4'h0, t + 3});
      wait_issue(ok);
      resolve_cf(k == 0, 8'h05, en, a);
      n_chk++;
      if (!ok || en !== 1'b1 || a !== ((k == 0) ? 8'h05 : 8'h21)) begin
        n_fail++;
        $display("FAIL jcc_redirect[taken=%0d]: ok=%b en=%b addr=%h, want en=1 addr=%h",
                 k == 0, ok, en, a, (k == 0) ? 8'h05 : 8'h21);
      end
      wait_done(d, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL jcc_done: timeout, want done"); end
    end
  endtask

  task automatic test_call_ret;
    int t, d; bit ok; logic en; logic [7:0] a;
    do_start(8'h30, t);
    sb.push_back('{8'h30, OP_CALL, BLINK, t + 3});
    wait_issue(ok);
    resolve_cf(1'b1, 8'h40, en, a);
    n_chk++;
    if (!ok || en !== 1'b1 || a !== 8'h40) begin
      n_fail++;
      $display("FAIL call_redirect: en=%b addr=%h, want en=1 addr=40", en, a);
    end
    sb.push_back('{8'h40, OP_RET, 4'h0, -1});
    wait_issue(ok);
    resolve_cf(1'b1, 8'h31, en, a);
    n_chk++;
    if (!ok || en !== 1'b1 || a !== 8'h31) begin
      n_fail++;
      $display("FAIL ret_redirect: ok=%b en=%b addr=%h, want en=1 addr=31", ok, en, a);
    end
    wait_done(d, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL call_done: timeout, want done"); end
  endtask

  task automatic test_await_wrap;
    int t, d; bit ok; logic en; logic [7:0] a;
    do_start(8'h7F, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    await_evt = 1'b1;  // lands in the ISSUE cycle and must be dropped
    @(posedge clk); #1;
    await_evt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (rom_en !== 1'b0 || issue_vld !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL await_stall[%0d]: en=%b iv=%b busy=%b, want 0 0 1", i, rom_en, issue_vld, busy);
      end
    end
    @(posedge clk); #1 await_evt = 1'b1;
    @(posedge clk); #1 await_evt = 1'b0;
    en = rom_en; a = rom_addr;
    n_chk++;
    if (en !== 1'b1 || a !== 8'h80) begin
      n_fail++;
      $display("FAIL await_wake: en=%b addr=%h, want en=1 addr=80", en, a);
    end
    wait_done(d, ok);
    // pc wrap: ADD at 0xFF continues at 0x00
    do_start(8'hFF, t);
    sb.push_back('{8'hFF, OP_ADD, 4'h4, t + 3});
    wait_issue(ok);
    @(posedge clk); #1;
    n_chk++;
    if (!ok || rom_en !== 1'b1 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL pc_wrap: en=%b addr=%h, want en=1 addr=00", rom_en, rom_addr);
    end
    wait_done(d, ok);
  endtask

  task automatic test_invalid_back_to_back;
    int t, d; bit ok;
    do_start(8'h60, t);
    wait_done(d, ok);
    n_chk++;
    if (!ok || d != t + 4 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_term: ok=%b cyc=%0d err=%b, want cyc=%0d err=1", ok, d, err, t + 4);
    end
    // start in the done cycle must be accepted and clear err
    start_vld = 1'b1; start_pc = 8'h12;
    @(posedge clk); #1 start_vld = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || err !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 8'h12) begin
      n_fail++;
      $display("FAIL b2b_start: busy=%b err=%b en=%b addr=%h, want 1 0 1 12", busy, err, rom_en, rom_addr);
    end
    wait_done(d, ok);
    n_chk++;
    if (!ok || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: ok=%b err=%b, want done with err=0", ok, err);
    end
  endtask

  task automatic test_rst_cf_wait;
    int t; bit ok;
    do_start(8'h20, t);
    sb.push_back('{8'h20, OP_JCC, 4'h0, t + 3});
    wait_issue(ok);
    @(posedge clk); #1 rst = 1'b1;  // now in CF_WAIT
    @(posedge clk); #1 rst = 1'b0;
    n_chk++;
    if (!ok || busy !== 1'b0 || start_rdy !== 1'b1 || rom_en !== 1'b0 || issue_vld !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_cf_wait: busy=%b rdy=%b en=%b iv=%b done=%b err=%b addr=%h, want 0 1 0 0 0 0 00",
               busy, start_rdy, rom_en, issue_vld, done, err, rom_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = mk(4'd8, 4'h0, 8'h00);
    rom_mem[8'h10] = mk(4'd1, 4'h1, 8'h00);
    rom_mem[8'h11] = mk(4'd3, 4'h2, 8'h00);
    rom_mem[8'h12] = mk(4'd8, 4'h0, 8'h00);
    rom_mem[8'h50] = mk(4'd1, 4'h3, 8'hA5);
    rom_mem[8'h20] = mk(4'd4, 4'h0, 8'h05);
    rom_mem[8'h30] = mk(4'd5, 4'h0, 8'h40);
    rom_mem[8'h40] = mk(4'd6, 4'h0, 8'h00);
    rom_mem[8'h7F] = mk(4'd7, 4'h0, 8'h00);
    rom_mem[8'hFF] = mk(4'd1, 4'h4, 8'h00);
    rom_mem[8'h60] = mk(4'hE, 4'h0, 8'h00);

    test_reset();
    test_straight_line();
    test_backpressure();
    test_jcc();
    test_call_ret();
    test_await_wrap();
    test_invalid_back_to_back();
    test_rst_cf_wait();

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d issues outstanding, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qs_srt_ucode_sequencer.md
# qs_srt_ucode_sequencer

Fetch/issue controller for the qs_srt microcode engine. Accepts a start request with an entry PC, fetches instructions from the synchronous microcode ROM, decodes them through the shared ucode decoder, and issues ucode words to the execute stage over a valid/ready handshake. Resolves control flow: sequential, JCC/CALL/RET redirect, AWAIT stall, DONE/invalid termination. One instruction is in flight at a time.

## Interface
- PC_W, 8, microcode address width; PC wraps modulo 2^PC_W
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_vld  in  1  start request
- start_pc  in  PC_W  entry address
- start_rdy  out  1  high only in IDLE
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on program termination
- err  out  1  sticky; set on invalid instruction, cleared on next accepted start
- rom_en  out  1  ROM read enable
- rom_addr  out  PC_W  ROM read address (= pc)
- rom_data  in  qs_srt_pkg::inst_t  valid the cycle after rom_en
- issue_vld  out  1  ucode valid to execute
- issue_ucode  out  qs_srt_pkg::ucode_t  decoded instruction
- issue_pc  out  PC_W  PC of issued instruction (execute uses it for CALL link = pc+1)
- issue_rdy  in  1  execute accepts
- cf_vld  in  1  control-flow resolution from execute
- cf_taken  in  1  redirect taken
- cf_target  in  PC_W  redirect address (JCC target or BLINK for RET)
- await_evt  in  1  wake event for AWAIT

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, CF_WAIT, AWAIT.
- IDLE: start_rdy=1. start_vld -> pc=start_pc, err=0, -> FETCH.
- FETCH: rom_en=1, rom_addr=pc -> LOAD.
- LOAD: inst_q <= rom_data -> ISSUE.
- ISSUE: ucode decoded combinationally from inst_q. By class:
  - NOP: not issued; pc+1 -> FETCH.
  - invalid_inst: not issued; err=1, done pulse -> IDLE.
  - is_done: not issued; done pulse -> IDLE.
  - is_await: not issued -> AWAIT.
  - is_jump or is_ret (JCC, CALL, RET): issue_vld=1; on issue_vld&issue_rdy -> CF_WAIT.
  - all others: issue_vld=1; on handshake pc+1 -> FETCH.
  - issue_vld held and issue_ucode/issue_pc stable until issue_rdy.
- CF_WAIT: on cf_vld: pc = cf_taken ? cf_target : pc+1 -> FETCH. cf_vld outside CF_WAIT ignored.
- AWAIT: on await_evt: pc+1 -> FETCH. An await_evt seen in the ISSUE cycle is not remembered.
- start_vld outside IDLE ignored.
- pc+1 from 2^PC_W-1 wraps to 0.

## Timing
- Reset: state IDLE, pc=0, inst_q=0, err=0; done, issue_vld, rom_en low; start_rdy=1, busy=0.
- Start accepted in cycle T: rom_en at T+1, inst_q loaded at T+2, issue_vld at T+3.
- Straight-line with issue_rdy=1: one instruction per 3 cycles.
- Control flow: earliest next rom_en is the cycle after cf_vld (cf_vld no earlier than handshake+1).
- done is registered: high in the first IDLE cycle. A start_vld in that cycle is accepted.
- rst mid-program: sequencer returns to the reset state next cycle. An in-flight issue is dropped without a handshake.

## Structure
- qs_srt_pkg gains seq_state_t (enum for the six states). inst_t, ucode_t and BLINK are reused from the package.
- Single sub-module: an instance of qs_srt_ucode_decoder (inst_q -> issue_ucode).
- PC register, inst_q, state register and err flag are local to this module.

## Test plan
- Straight-line: start_pc=0x10, ROM holds ADD, MOV, DONE, issue_rdy=1 -> issues at T+3, T+6 with issue_pc 0x10, 0x11; done pulses at T+10; busy falls at the same cycle.
- Backpressure: issue_rdy low 4 cycles on an ADD -> issue_vld, issue_ucode, issue_pc held stable; pc advances only after the handshake.
- JCC at 0x20: resolve with cf_taken=1, cf_target=0x05 -> next rom_addr=0x05. Repeat with cf_taken=0 -> next rom_addr=0x21.
- CALL at 0x30 then RET at target: CALL issued with issue_pc=0x30, taken to 0x40. RET issued and resolved with cf_target=0x31 -> fetch resumes at 0x31.
- AWAIT at 0x7F, await_evt after 6 cycles -> no issue, rom_en stays low until then, next rom_addr=0x80. Also, with PC_W=8, an ADD at 0xFF wraps pc to 0x00.
- Invalid opcode -> not issued, err=1 and done pulse. A later start clears err. A rst asserted in CF_WAIT -> IDLE next cycle, all outputs at reset values.
